// File: rtl/adder_measure_sequencer_if.sv
// Adder-macro side of the measurement sequencer: operand drive, ring control,
// and the adder's observable outputs.
interface adder_measure_sequencer_if;
    logic [31:0] a_input;
    logic [31:0] b_input;
    logic        ring_en;
    logic        count_clr;
    logic [31:0] ring_count;
    logic [31:0] s_output;
    logic        chain_out;

    modport master (
        output a_input, b_input, ring_en, count_clr,
        input  ring_count, s_output, chain_out
    );

    modport slave (
        input  a_input, b_input, ring_en, count_clr,
        output ring_count, s_output, chain_out
    );
endinterface

// File: rtl/adder_measure_sequencer.sv
// Measurement sequencer for the instrumented Brent-Kung adder: load, settle, gate the
// ring oscillator, drain, capture. Define ACCUM_EN to accumulate repeat_n back-to-back runs.
module adder_measure_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES  = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [31:0]               a_in,
    input  logic [31:0]               b_in,
    input  logic [15:0]               gate_cycles,
    input  logic [7:0]                repeat_n,
    adder_measure_sequencer_if.master adder,
    output logic                      busy,
    output logic                      done,
    output logic                      start_err,
    output logic [31:0]               result,
    output logic                      sum_err
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_GATE,
        ST_DRAIN,
        ST_CAPTURE
    } state_e;

    state_e      state_q;
    logic [15:0] gate_q;
    logic [15:0] cnt_q;
    logic [31:0] a_input_q;
    logic [31:0] b_input_q;
    logic        ring_en_q;
    logic        count_clr_q;
    logic        done_q;
    logic        start_err_q;
    logic [31:0] result_q;
    logic        sum_err_q;

    logic [32:0] sum_exp_d;
    logic        mismatch_d;
    logic [31:0] result_d;

    // a_input_q/b_input_q double as the operand latch; they only move on entry to LOAD.
    assign sum_exp_d  = {1'b0, a_input_q} + {1'b0, b_input_q};
    assign mismatch_d = ({adder.chain_out, adder.s_output} != sum_exp_d);

`ifdef ACCUM_EN
    logic [7:0]  runs_q;
    logic [32:0] acc_d;

    assign acc_d    = {1'b0, result_q} + {1'b0, adder.ring_count};
    assign result_d = acc_d[32] ? '1 : acc_d[31:0];
`else
    logic unused_repeat;

    assign unused_repeat = ^repeat_n;
    assign result_d      = adder.ring_count;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= ST_IDLE;
            gate_q      <= '0;
            cnt_q       <= '0;
            a_input_q   <= '0;
            b_input_q   <= '0;
            ring_en_q   <= 1'b0;
            count_clr_q <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            result_q    <= '0;
            sum_err_q   <= 1'b0;
`ifdef ACCUM_EN
            runs_q      <= '0;
`endif
        end else begin
            count_clr_q <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                state_q   <= ST_IDLE;
                ring_en_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (gate_cycles != '0) begin
                                a_input_q   <= a_in;
                                b_input_q   <= b_in;
                                gate_q      <= gate_cycles;
                                result_q    <= '0;
                                sum_err_q   <= 1'b0;
                                count_clr_q <= 1'b1;
                                state_q     <= ST_LOAD;
`ifdef ACCUM_EN
                                runs_q      <= (repeat_n == '0) ? 8'd1 : repeat_n;
`endif
                            end else begin
                                start_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        cnt_q   <= SETTLE_LAST;
                        state_q <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cnt_q == '0) begin
                            cnt_q     <= gate_q - 16'd1;
                            ring_en_q <= 1'b1;
                            state_q   <= ST_GATE;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_GATE: begin
                        if (cnt_q == '0) begin
                            cnt_q     <= DRAIN_LAST;
                            ring_en_q <= 1'b0;
                            state_q   <= ST_DRAIN;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        result_q  <= result_d;
                        sum_err_q <= sum_err_q | mismatch_d;
`ifdef ACCUM_EN
                        if (runs_q > 8'd1) begin
                            runs_q      <= runs_q - 8'd1;
                            count_clr_q <= 1'b1;
                            state_q     <= ST_LOAD;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
`else
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
`endif
                    end
                    default: begin
                        ring_en_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign adder.a_input   = a_input_q;
    assign adder.b_input   = b_input_q;
    assign adder.ring_en   = ring_en_q;
    assign adder.count_clr = count_clr_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign start_err       = start_err_q;
    assign result          = result_q;
    assign sum_err         = sum_err_q;

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Self-checking bench for adder_measure_sequencer: directed table, corner sequences,
// and randomized runs checked against a run-level reference model.
module tb_adder_measure_sequencer;

    localparam int S = 4;
    localparam int D = 4;
`ifdef ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] g;
        logic [7:0]  rep;
        logic        mode;      // 0: constant ring_count, 1: counting ring model
        logic [31:0] val;
        logic [31:0] rate;
        logic [1:0]  fault;     // 0 none, 1 chain_out stuck 0, 2 sum bit 0 flipped
        logic        abt;       // abort held high alongside the accepted start
        int          runs;
        logic [31:0] exp_res;
        logic        exp_serr;
        int          exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [31:0] a_in, b_in;
    logic [15:0] gate_cycles;
    logic [7:0]  repeat_n;
    logic        busy, done, start_err, sum_err;
    logic [31:0] result;

    logic        ring_mode = 1'b0;
    logic [31:0] ring_val = '0;
    logic [31:0] rate = '0;
    logic [1:0]  fault = '0;
    logic [31:0] ring_ctr = '0;
    logic [32:0] true_sum;

    int checks = 0;
    int errors = 0;

    adder_measure_sequencer_if aif ();

    adder_measure_sequencer #(
        .SETTLE_CYCLES(S),
        .DRAIN_CYCLES (D)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .start      (start),
        .abort      (abort),
        .a_in       (a_in),
        .b_in       (b_in),
        .gate_cycles(gate_cycles),
        .repeat_n   (repeat_n),
        .adder      (aif),
        .busy       (busy),
        .done       (done),
        .start_err  (start_err),
        .result     (result),
        .sum_err    (sum_err)
    );

    always #5 clk = ~clk;

    // Adder and ring-counter models.
    always_comb begin
        true_sum      = {1'b0, aif.a_input} + {1'b0, aif.b_input};
        aif.s_output  = true_sum[31:0] ^ {31'b0, (fault == 2'd2)};
        aif.chain_out = (fault == 2'd1) ? 1'b0 : true_sum[32];
    end
    assign aif.ring_count = ring_mode ? ring_ctr : ring_val;

    always @(posedge clk) begin
        if (aif.count_clr) ring_ctr <= '0;
        else if (aif.ring_en) ring_ctr <= ring_ctr + rate;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        logic [32:0] acc, tsum, obs;
        logic [31:0] per;
        v.runs = (ACCUM && v.rep != 8'd0) ? int'(v.rep) : 1;
        per = v.mode ? 32'(v.g * v.rate) : v.val;
        acc = '0;
        for (int r = 0; r < v.runs; r++) begin
            acc = acc + {1'b0, per};
            if (acc[32]) acc = 33'h0_FFFF_FFFF;
        end
        v.exp_res = acc[31:0];
        tsum = {1'b0, v.a} + {1'b0, v.b};
        obs  = tsum;
        if (v.fault == 2'd1) obs[32] = 1'b0;
        if (v.fault == 2'd2) obs[0] = ~obs[0];
        v.exp_serr = (obs != tsum);
        v.exp_done = v.runs * (S + int'(v.g) + D + 2) + 1;
        return v;
    endfunction

    task automatic run_meas(input vec_t v, input bit bad);
        int k, done_cyc, ren, first, clr, busyc, errp;
        @(negedge clk);
        ring_mode = v.mode; ring_val = v.val; rate = v.rate; fault = v.fault;
        a_in = v.a; b_in = v.b; gate_cycles = v.g; repeat_n = v.rep;
        start = 1'b1; abort = v.abt;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        k = 1; done_cyc = 0; ren = 0; first = -1; clr = 0; busyc = 0; errp = 0;
        while (k <= 1500) begin
            if (aif.ring_en) begin ren++; if (first < 0) first = k; end
            if (aif.count_clr) clr++;
            if (busy) busyc++;
            if (start_err) errp++;
            if (done) begin done_cyc = k; break; end
            if (bad && k == 3) begin start = 1'b1; gate_cycles = '0; end
            if (bad && k == S + 1) start = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("done_seen", 64'(done_cyc != 0), 64'd1);
        chk("result", 64'(result), 64'(v.exp_res));
        chk("sum_err", 64'(sum_err), 64'(v.exp_serr));
        chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        chk("ring_en_cycles", 64'(ren), 64'(int'(v.g) * v.runs));
        chk("ring_en_first", 64'(first), 64'(S + 2));
        chk("count_clr_pulses", 64'(clr), 64'(v.runs));
        chk("busy_cycles", 64'(busyc), 64'(done_cyc - 1));
        chk("no_start_err", 64'(errp), 64'd0);
        chk("a_input", 64'(aif.a_input), 64'(v.a));
        chk("b_input", 64'(aif.b_input), 64'(v.b));
        @(negedge clk);
        chk("done_width", 64'(done), 64'd0);
    endtask

    vec_t tbl[5];
    vec_t v;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{a:32'h80, b:32'h80, g:16'd10, rep:8'd1, mode:1'b0, val:32'd123, rate:32'd0,
                   fault:2'd0, abt:1'b0, runs:1, exp_res:32'd123, exp_serr:1'b0, exp_done:21};
        tbl[1] = '{a:32'hFFFF_FFFF, b:32'h1, g:16'd10, rep:8'd1, mode:1'b0, val:32'd77, rate:32'd0,
                   fault:2'd0, abt:1'b0, runs:1, exp_res:32'd77, exp_serr:1'b0, exp_done:21};
        tbl[2] = '{a:32'hFFFF_FFFF, b:32'h1, g:16'd10, rep:8'd1, mode:1'b0, val:32'd77, rate:32'd0,
                   fault:2'd1, abt:1'b0, runs:1, exp_res:32'd77, exp_serr:1'b1, exp_done:21};
        tbl[3] = '{a:32'h1234_5678, b:32'h9ABC_DEF0, g:16'd1, rep:8'd1, mode:1'b1, val:32'd0, rate:32'd5,
                   fault:2'd2, abt:1'b0, runs:1, exp_res:32'd5, exp_serr:1'b1, exp_done:12};
        tbl[4] = '{a:32'h0, b:32'h0, g:16'd3, rep:8'd1, mode:1'b1, val:32'd0, rate:32'h1000,
                   fault:2'd0, abt:1'b1, runs:1, exp_res:32'h3000, exp_serr:1'b0, exp_done:14};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        a_in = '0; b_in = '0; gate_cycles = '0; repeat_n = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {aif.a_input, aif.b_input},  64'd0);
        chk("reset_flags", 64'({aif.ring_en, aif.count_clr, busy, done, start_err, sum_err}), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_meas(tbl[i], (i == 1));

        // Rejected start: zero gate window.
        @(negedge clk);
        start = 1'b1; gate_cycles = '0; a_in = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        chk("start_err_pulse", 64'({start_err, busy}), 64'b10);
        @(negedge clk);
        chk("start_err_width", 64'(start_err), 64'd0);
        begin
            int en = 0, bz = 0;
            repeat (10) begin @(negedge clk); if (aif.ring_en) en++; if (busy) bz++; end
            chk("start_err_idle", 64'(en + bz), 64'd0);
        end
        chk("start_err_latch", 64'(aif.a_input), 64'(tbl[4].a));

        // Abort on the second GATE cycle.
        @(negedge clk);
        ring_mode = 1'b0; ring_val = 32'd999; fault = 2'd1;
        a_in = 32'hFFFF_FFFF; b_in = 32'h1; gate_cycles = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk("abort_pre_ring_en", 64'(aif.ring_en), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_state", 64'({aif.ring_en, busy}), 64'd0);
        begin
            int dn = 0, en = 0;
            repeat (30) begin @(negedge clk); if (done) dn++; if (aif.ring_en) en++; end
            chk("abort_no_done", 64'(dn + en), 64'd0);
        end
        chk("abort_result_held", 64'({sum_err, result}), 64'd0);
        fault = 2'd0;
        run_meas(tbl[0], 1'b0);

        // Reset asserted during GATE takes effect without a clock edge.
        @(negedge clk);
        ring_mode = 1'b0; a_in = 32'h5555_0000; b_in = 32'h0000_AAAA; gate_cycles = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk("reset_pre_ring_en", 64'(aif.ring_en), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_bus", {aif.a_input, aif.b_input}, 64'd0);
        chk("async_reset_flags", 64'({aif.ring_en, aif.count_clr, busy, done, start_err, sum_err}), 64'd0);
        chk("async_reset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturating accumulation (single run when accumulation is not built in).
        v = '{a:32'h7, b:32'h9, g:16'd10, rep:8'd3, mode:1'b0, val:32'h6000_0000, rate:32'd0,
              fault:2'd0, abt:1'b0, runs:1, exp_res:32'h0, exp_serr:1'b0, exp_done:0};
        run_meas(model(v), 1'b0);
        v.rep = 8'd0;
        run_meas(model(v), 1'b0);

        for (int i = 0; i < 20; i++) begin
            v.a = $urandom; v.b = $urandom;
            v.g = 16'($urandom_range(1, 40));
            v.rep = 8'($urandom_range(0, 4));
            v.mode = 1'($urandom_range(0, 1));
            v.val = $urandom;
            v.rate = $urandom_range(1, 1000);
            v.fault = 2'($urandom_range(0, 2));
            v.abt = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) v.b = ~v.a + 32'd1;
            run_meas(model(v), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_measure_sequencer.md
# adder_measure_sequencer

Measurement sequencer for the instrumented Brent-Kung adder macro. It latches a pair of operands, presents them to the adder, and lets the adder outputs settle. It then opens the adder's ring-oscillator enable for a programmed gate window, waits for the ring counter to drain, and captures both the ring count and the adder sum. It sits between the logic-analyzer/Wishbone-facing control registers and the adder wrapper, and owns every control input of the adder.

## Interface
Parameters:
- SETTLE_CYCLES, 4: cycles between operand load and ring enable (≥1).
- DRAIN_CYCLES, 4: cycles between ring disable and count capture (≥1).

Ports:
- wb_clk_i  input  1  system clock; all state updates on rising edge.
- wb_rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a measurement; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- a_in  input  32  operand A, latched on accepted start.
- b_in  input  32  operand B, latched on accepted start.
- gate_cycles  input  16  ring-enable window length in clocks; latched on accepted start.
- repeat_n  input  8  number of runs to accumulate; latched on accepted start (used only with ACCUM_EN).
- a_input  output  32  operand A driven to the adder.
- b_input  output  32  operand B driven to the adder.
- ring_en  output  1  adder ring-oscillator enable.
- count_clr  output  1  clears the adder ring counter.
- ring_count  input  32  adder ring counter; stable during DRAIN/CAPTURE.
- s_output  input  32  adder sum.
- chain_out  input  1  adder carry out.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when results are valid.
- start_err  output  1  one-cycle pulse when start is rejected.
- result  output  32  captured (or accumulated) ring count.
- sum_err  output  1  sticky per measurement: captured {chain_out,s_output} ≠ a+b (33-bit).

## Operation
- States: IDLE, LOAD, SETTLE, GATE, DRAIN, CAPTURE.
- IDLE: start=1 with gate_cycles≠0 → latch a_in, b_in, gate_cycles, repeat_n; go to LOAD; clear sum_err and result. start=1 with gate_cycles=0 → start_err pulse next cycle, stay in IDLE, latched values unchanged.
- LOAD (1 cycle): a_input/b_input take the latched operands; count_clr=1.
- SETTLE: SETTLE_CYCLES cycles, ring_en=0.
- GATE: exactly gate_cycles cycles with ring_en=1.
- DRAIN: DRAIN_CYCLES cycles, ring_en=0.
- CAPTURE (1 cycle): result ← ring_count (or accumulated, see Configuration); sum_err ← sum_err | ({chain_out,s_output} ≠ {1'b0,a}+{1'b0,b}). Then go to IDLE (or to LOAD for the next accumulated run). done=1 in the first IDLE cycle.
- a_input/b_input hold their last value in IDLE; they change only in LOAD.
- abort in any non-IDLE state: next cycle is IDLE, ring_en=0, no done, result and sum_err hold their last values. abort in IDLE has no effect. When start and abort are both high in IDLE, start wins.
- start while busy is ignored (no start_err).

## Timing
- Reset values: a_input=0, b_input=0, ring_en=0, count_clr=0, busy=0, done=0, start_err=0, result=0, sum_err=0; state IDLE.
- Timeline for a single run, with the cycle in which start is accepted numbered 0:
  - LOAD: cycle 1.
  - SETTLE: cycles 2..S+1.
  - GATE: cycles S+2..S+G+1.
  - DRAIN: the next D cycles.
  - CAPTURE: cycle S+G+D+2.
  - done: cycle S+G+D+3.
- ring_en is high for exactly G consecutive cycles per run. count_clr is high for exactly 1 cycle per run.
- Reset asserted mid-measurement immediately forces ring_en=0 and all outputs to their reset values.

## Configuration
- ACCUM_EN defined:
  - repeat_n runs are executed back-to-back; repeat_n=0 is treated as 1.
  - CAPTURE of each non-final run goes directly to LOAD.
  - result = saturating 32-bit sum of all runs' ring_count, clamped at 0xFFFFFFFF.
  - sum_err is the OR over all runs.
  - done pulses once, after the final run.
- ACCUM_EN undefined: repeat_n is ignored; a single run is executed and result = ring_count.

## Test plan
- Single run, defaults: a=0x00000080, b=0x00000080, G=10, ring_count model = 123, correct adder → ring_en high for exactly 10 cycles, done at cycle 21, result=123, sum_err=0.
- Carry case: a=0xFFFFFFFF, b=1, adder returns s=0 with chain_out=1 → sum_err=0. Same stimulus with a faulty model returning chain_out=0 → sum_err=1.
- start with gate_cycles=0 → start_err pulse at cycle 1, busy stays 0, ring_en never asserts.
- abort raised during cycle 2 of GATE → ring_en low the next cycle, busy=0, no done, result unchanged. A subsequent start then runs normally.
- Reset deasserted then reasserted during GATE → ring_en=0 and all outputs 0 immediately, without waiting for a clock edge.
- ACCUM_EN, repeat_n=3, ring_count model=0x60000000 per run → three count_clr pulses, one done, result=0xFFFFFFFF (saturated). With repeat_n=0 → single run.
